// File: rtl/ball_pad_ctrl.sv
// Pong game logic: once per video frame it moves the ball, bounces it off the
// walls and pads, scores misses, and steps through serve / play / game-over.
module ball_pad_ctrl #(
    parameter int H_RES        = 1024,
    parameter int V_RES        = 768,
    parameter int BALL_SIZE    = 15,
    parameter int PAD_HEIGHT   = 145,
    parameter int PAD_WIDTH    = 15,
    parameter int X_PAD_LEFT   = 30,
    parameter int X_PAD_RIGHT  = 979,
    parameter int SPEED_X      = 4,
    parameter int SPEED_Y      = 3,
    parameter int X_START      = 504,
    parameter int Y_START      = 376,
    parameter int SERVE_FRAMES = 60,
    parameter int MAX_SCORE    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        start,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [10:0] y_ball,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        point_left,
    output logic        point_right,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;

    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic signed [11:0] SX         = 12'(SPEED_X);
    localparam logic signed [11:0] SY         = 12'(SPEED_Y);
    localparam logic signed [11:0] BALL       = 12'(BALL_SIZE);
    localparam logic signed [11:0] PAD_H      = 12'(PAD_HEIGHT);
    localparam logic signed [11:0] PAD_L_EDGE = 12'(X_PAD_LEFT + PAD_WIDTH);
    localparam logic signed [11:0] PAD_R_EDGE = 12'(X_PAD_RIGHT);
    localparam logic signed [11:0] X_MISS_R   = 12'(H_RES - 1);
    localparam logic signed [11:0] Y_BOTTOM   = 12'(V_RES - 1);

    localparam logic [10:0] X_HIT_L     = 11'(X_PAD_LEFT + PAD_WIDTH + 1);
    localparam logic [10:0] X_HIT_R     = 11'(X_PAD_RIGHT - BALL_SIZE - 1);
    localparam logic [10:0] Y_CLAMP_BOT = 11'(V_RES - 1 - BALL_SIZE);
    localparam logic [10:0] X_ST        = 11'(X_START);
    localparam logic [10:0] Y_ST        = 11'(Y_START);
    localparam logic [3:0]  SCORE_MAX   = 4'(MAX_SCORE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vblnk_q;
    logic             dx_neg_q, dx_neg_d;
    logic             dy_neg_q, dy_neg_d;
    logic [10:0]      x_d, y_d;
    logic [3:0]       sl_d, sr_d;
    logic             pl_d, pr_d;

    logic               tick;
    logic signed [11:0] xs, ys, ypl, ypr, nx, ny;
    logic               hit_l, hit_r, miss_l, miss_r;

    assign tick      = vblnk & ~vblnk_q;
    assign game_over = (state_q == GAME_OVER);

    // Geometry is evaluated in signed 12 bits so a step past the left or top edge goes negative.
    assign xs  = signed'({1'b0, x_ball});
    assign ys  = signed'({1'b0, y_ball});
    assign ypl = signed'({2'b00, y_pad_left});
    assign ypr = signed'({2'b00, y_pad_right});
    assign nx  = xs + (dx_neg_q ? -SX : SX);
    assign ny  = ys + (dy_neg_q ? -SY : SY);

    assign hit_l  = dx_neg_q && (nx <= PAD_L_EDGE) && (xs > PAD_L_EDGE)
                    && (ys + BALL >= ypl) && (ys <= ypl + PAD_H);
    assign hit_r  = !dx_neg_q && (nx + BALL >= PAD_R_EDGE) && (xs + BALL < PAD_R_EDGE)
                    && (ys + BALL >= ypr) && (ys <= ypr + PAD_H);
    assign miss_r = !dx_neg_q && (nx + BALL >= X_MISS_R);
    assign miss_l = dx_neg_q && (nx <= 12'sd0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_ball;
        y_d      = y_ball;
        dx_neg_d = dx_neg_q;
        dy_neg_d = dy_neg_q;
        sl_d     = score_left;
        sr_d     = score_right;
        pl_d     = 1'b0;
        pr_d     = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = SERVE;
                        cnt_d   = '0;
                    end
                end
                SERVE: begin
                    if (cnt_q == CNT_LAST) state_d = PLAY;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                PLAY: begin
                    if (ny <= 12'sd0) begin
                        y_d      = '0;
                        dy_neg_d = 1'b0;
                    end else if (ny + BALL >= Y_BOTTOM) begin
                        y_d      = Y_CLAMP_BOT;
                        dy_neg_d = 1'b1;
                    end else begin
                        y_d = ny[10:0];
                    end

                    if (hit_l) begin
                        x_d      = X_HIT_L;
                        dx_neg_d = 1'b0;
                    end else if (hit_r) begin
                        x_d      = X_HIT_R;
                        dx_neg_d = 1'b1;
                    end else if (miss_r || miss_l) begin
                        // The player who conceded receives the next serve.
                        x_d      = X_ST;
                        y_d      = Y_ST;
                        dx_neg_d = miss_l;
                        dy_neg_d = 1'b0;
                        cnt_d    = '0;
                        if (miss_r) begin
                            pl_d = 1'b1;
                            if (score_left < SCORE_MAX) sl_d = score_left + 4'd1;
                        end else begin
                            pr_d = 1'b1;
                            if (score_right < SCORE_MAX) sr_d = score_right + 4'd1;
                        end
                        state_d = (sl_d == SCORE_MAX || sr_d == SCORE_MAX) ? GAME_OVER : SERVE;
                    end else begin
                        x_d = nx[10:0];
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        sl_d     = '0;
                        sr_d     = '0;
                        dx_neg_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = SERVE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vblnk_q     <= 1'b0;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            x_ball      <= X_ST;
            y_ball      <= Y_ST;
            score_left  <= '0;
            score_right <= '0;
            point_left  <= 1'b0;
            point_right <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every register sample the pre-edge values computed above.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vblnk_q     <= vblnk;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            x_ball      <= x_d;
            y_ball      <= y_d;
            score_left  <= sl_d;
            score_right <= sr_d;
            point_left  <= pl_d;
            point_right <= pr_d;
        end
    end

endmodule

// File: tb/tb_ball_pad_ctrl.sv
// Bench for ball_pad_ctrl: a frame-level game model feeds a scoreboard, plus
// hand-derived positions for serve timing, wall clamp, pad bounces and scoring.
module tb_ball_pad_ctrl;

    localparam int SERVE_FRAMES = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  y_pad_left = '0;
    logic [9:0]  y_pad_right = '0;
    logic [10:0] x_ball, y_ball;
    logic [3:0]  score_left, score_right;
    logic        point_left, point_right, game_over;

    always #5 clk = ~clk;

    ball_pad_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (vblnk),
        .start       (start),
        .y_pad_left  (y_pad_left),
        .y_pad_right (y_pad_right),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .score_left  (score_left),
        .score_right (score_right),
        .point_left  (point_left),
        .point_right (point_right),
        .game_over   (game_over)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        pl;
        logic        pr;
        logic        go;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Frame-level reference model of the game.
    int m_x, m_y, m_dx, m_dy, m_state, m_cnt, m_sl, m_sr;
    bit m_pl, m_pr;

    function automatic string fmt(input exp_t v);
        return $sformatf("x=%0d y=%0d sl=%0d sr=%0d pl=%0b pr=%0b go=%0b",
                         v.x, v.y, v.sl, v.sr, v.pl, v.pr, v.go);
    endfunction

    function automatic exp_t dut_now();
        return {x_ball, y_ball, score_left, score_right, point_left, point_right, game_over};
    endfunction

    function automatic exp_t model_out();
        exp_t v;
        v.x  = 11'(m_x);
        v.y  = 11'(m_y);
        v.sl = 4'(m_sl);
        v.sr = 4'(m_sr);
        v.pl = m_pl;
        v.pr = m_pr;
        v.go = (m_state == 3);
        return v;
    endfunction

    function automatic int track(input int y);
        return (y >= 50) ? y - 50 : 0;
    endfunction

    function automatic int dodge(input int y);
        return (y >= 300) ? 0 : 600;
    endfunction

    task automatic model_reset();
        m_x = 504; m_y = 376; m_dx = 1; m_dy = 1;
        m_state = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0;
    endtask

    task automatic model_tick(input bit st, input int ypl, input int ypr);
        int nx, ny, oy;
        m_pl = 0;
        m_pr = 0;
        case (m_state)
            0: if (st) begin m_state = 1; m_cnt = 0; end
            1: if (m_cnt == SERVE_FRAMES - 1) m_state = 2; else m_cnt++;
            2: begin
                nx = m_x + 4 * m_dx;
                ny = m_y + 3 * m_dy;
                oy = m_y;
                if (ny <= 0) begin m_y = 0; m_dy = 1; end
                else if (ny + 15 >= 767) begin m_y = 752; m_dy = -1; end
                else m_y = ny;
                if (m_dx < 0 && nx <= 45 && m_x > 45 && oy + 15 >= ypl && oy <= ypl + 145) begin
                    m_x = 46; m_dx = 1;
                end else if (m_dx > 0 && nx + 15 >= 979 && m_x + 15 < 979 &&
                             oy + 15 >= ypr && oy <= ypr + 145) begin
                    m_x = 963; m_dx = -1;
                end else if ((m_dx > 0 && nx + 15 >= 1023) || (m_dx < 0 && nx <= 0)) begin
                    if (m_dx > 0) begin m_sl++; m_pl = 1; end
                    else          begin m_sr++; m_pr = 1; end
                    m_dx = m_pr ? -1 : 1;
                    m_x = 504; m_y = 376; m_dy = 1; m_cnt = 0;
                    m_state = (m_sl == 9 || m_sr == 9) ? 3 : 1;
                end else begin
                    m_x = nx;
                end
            end
            3: if (st) begin m_sl = 0; m_sr = 0; m_dx = 1; m_cnt = 0; m_state = 1; end
            default: m_state = 0;
        endcase
    endtask

    // One video frame: vblnk rises at a negedge, the update lands on the next posedge.
    task automatic frame(input bit st, input int ypl, input int ypr, input int hold);
        exp_t prev, e, got;
        prev    = model_out();
        prev.pl = 1'b0;
        prev.pr = 1'b0;
        model_tick(st, ypl, ypr);
        sb.push_back(model_out());
        @(negedge clk);
        vblnk       = 1'b1;
        start       = st;
        y_pad_left  = 10'(ypl);
        y_pad_right = 10'(ypr);
        #1;
        got = dut_now();
        n_vec++;
        if (got !== prev) begin
            n_err++;
            $display("FAIL early_update @%0t: got %s, expected %s", $time, fmt(got), fmt(prev));
        end
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = dut_now();
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL frame_update @%0t: got %s, expected %s", $time, fmt(got), fmt(e));
        end
        e.pl = 1'b0;
        e.pr = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #1;
            got = dut_now();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL frame_hold @%0t: got %s, expected %s", $time, fmt(got), fmt(e));
            end
        end
        @(negedge clk);
        vblnk = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t rv, got;
        rv  = {11'd504, 11'd376, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        rst = 1'b0; vblnk = 1'b0; start = 1'b0;
        y_pad_left = '0; y_pad_right = '0;
        model_reset();
        sb.delete();
        #17;
        got = dut_now();
        n_vec++;
        if (got !== rv) begin
            n_err++;
            $display("FAIL reset_held: got %s, expected %s", fmt(got), fmt(rv));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = dut_now();
        n_vec++;
        if (got !== rv) begin
            n_err++;
            $display("FAIL reset_release: got %s, expected %s", fmt(got), fmt(rv));
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) frame(1'b0, 100 + 20 * i, 500 - 20 * i, 2);
        n_vec++;
        if (x_ball !== 11'd504 || y_ball !== 11'd376 || game_over !== 1'b0) begin
            n_err++;
            $display("FAIL idle_static: x=%0d y=%0d go=%0b, expected x=504 y=376 go=0",
                     x_ball, y_ball, game_over);
        end
    endtask

    task automatic test_serve();
        frame(1'b1, track(m_y), track(m_y), 2);
        // start is pulsed again mid-serve; it must not restart the countdown
        for (int t = 1; t <= 60; t++) frame(t >= 10 && t <= 12, track(m_y), track(m_y), 2);
        n_vec++;
        if (x_ball !== 11'd504 || y_ball !== 11'd376) begin
            n_err++;
            $display("FAIL serve_hold: x=%0d y=%0d after 60 serve ticks, expected 504/376", x_ball, y_ball);
        end
        frame(1'b0, track(m_y), track(m_y), 2);
        n_vec++;
        if (x_ball !== 11'd508 || y_ball !== 11'd379) begin
            n_err++;
            $display("FAIL first_move: x=%0d y=%0d, expected 508/379", x_ball, y_ball);
        end
    endtask

    task automatic test_vblnk_hold();
        frame(1'b0, track(m_y), track(m_y), 100);
        n_vec++;
        if (x_ball !== 11'd512 || y_ball !== 11'd382) begin
            n_err++;
            $display("FAIL vblnk_hold: x=%0d y=%0d, expected 512/382", x_ball, y_ball);
        end
    endtask

    // Both pads follow the ball, so the rally bounces off the right pad,
    // clamps at the bottom wall, then bounces off the left pad.
    task automatic test_rally();
        for (int k = 3; k <= 346; k++) begin
            frame(k % 50 == 0, track(m_y), track(m_y), 2);
            if (k == 115) begin
                n_vec++;
                if (x_ball !== 11'd963) begin
                    n_err++;
                    $display("FAIL right_pad_bounce: x=%0d, expected 963", x_ball);
                end
            end
            if (k == 126 || k == 127) begin
                n_vec++;
                if (y_ball !== ((k == 126) ? 11'd752 : 11'd749)) begin
                    n_err++;
                    $display("FAIL bottom_wall k=%0d: y=%0d, expected %0d", k, y_ball,
                             (k == 126) ? 752 : 749);
                end
            end
            if (k == 345 || k == 346) begin
                n_vec++;
                if (x_ball !== ((k == 345) ? 11'd46 : 11'd50)) begin
                    n_err++;
                    $display("FAIL left_pad_bounce k=%0d: x=%0d, expected %0d", k, x_ball,
                             (k == 345) ? 46 : 50);
                end
            end
        end
    endtask

    // Left pad dodges the ball so the right player scores until the game ends.
    task automatic test_game_over();
        int since;
        since = -1;
        test_reset();
        frame(1'b1, 0, 0, 2);
        for (int t = 0; t < 3000 && m_state != 3; t++) begin
            frame(1'b0, dodge(m_y), track(m_y), 2);
            if (m_pr && m_sr == 1) begin
                since = 0;
                n_vec++;
                if (score_right !== 4'd1 || score_left !== 4'd0 || x_ball !== 11'd504 ||
                    y_ball !== 11'd376 || point_right !== 1'b0) begin
                    n_err++;
                    $display("FAIL first_point: sr=%0d sl=%0d x=%0d y=%0d pr=%0b, expected 1 0 504 376 0",
                             score_right, score_left, x_ball, y_ball, point_right);
                end
            end else if (since >= 0) begin
                since++;
                if (since == 61) begin
                    n_vec++;
                    if (x_ball !== 11'd500 || y_ball !== 11'd379) begin
                        n_err++;
                        $display("FAIL serve_to_loser: x=%0d y=%0d, expected 500/379", x_ball, y_ball);
                    end
                end
            end
        end
        n_vec++;
        if (m_state != 3 || game_over !== 1'b1 || score_right !== 4'd9 || score_left !== 4'd0) begin
            n_err++;
            $display("FAIL game_over_reached: go=%0b sr=%0d sl=%0d, expected 1 9 0",
                     game_over, score_right, score_left);
        end
        for (int i = 0; i < 3; i++) frame(1'b0, 200, 200, 2);
        n_vec++;
        if (game_over !== 1'b1 || score_right !== 4'd9 || x_ball !== 11'd504) begin
            n_err++;
            $display("FAIL game_over_frozen: go=%0b sr=%0d x=%0d, expected 1 9 504",
                     game_over, score_right, x_ball);
        end
        frame(1'b1, 200, 200, 2);
        n_vec++;
        if (game_over !== 1'b0 || score_right !== 4'd0 || score_left !== 4'd0) begin
            n_err++;
            $display("FAIL restart: go=%0b sr=%0d sl=%0d, expected 0 0 0",
                     game_over, score_right, score_left);
        end
        for (int i = 1; i <= 61; i++) frame(1'b0, track(m_y), track(m_y), 2);
        n_vec++;
        if (x_ball !== 11'd508) begin
            n_err++;
            $display("FAIL restart_serve_dir: x=%0d, expected 508", x_ball);
        end
    endtask

    task automatic test_async_reset();
        exp_t rv, got;
        rv = {11'd504, 11'd376, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) frame(1'b0, track(m_y), track(m_y), 2);
        @(posedge clk);
        #2;
        vblnk = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        got = dut_now();
        n_vec++;
        if (got !== rv) begin
            n_err++;
            $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(rv));
        end
        vblnk = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) frame(1'b0, 300, 300, 2);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_serve();
        test_vblnk_hold();
        test_rally();
        test_game_over();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
